// File: rtl/phase_controller.sv
// rtl/phase_controller.sv - one-hot phase sequencer, instruction decoder and strobe generator (optional SINGLE_STEP_EN)
module phase_controller #(
    parameter int                NPHASE      = 5,
    parameter logic [NPHASE-1:0] RESET_PHASE = 5'b00001
) (
    input  logic              clock,
    input  logic              reset,
`ifdef SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [15:0]       instr,
    input  logic [3:0]        cond,
    output logic [NPHASE-1:0] phasecounter,
    output logic [2:0]        ALUSrc,
    output logic [3:0]        ALUOp,
    output logic [15:0]       ext_d,
    output logic [2:0]        ra_addr,
    output logic [2:0]        rb_addr,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [1:0]        wb_sel,
    output logic              mem_we,
    output logic              pc_inc,
    output logic              pc_we,
    output logic              out_we,
    output logic [3:0]        flags,
    output logic              halted
);

    localparam logic [NPHASE-1:0] P1_ONEHOT = {{(NPHASE-1){1'b0}}, 1'b1};

    logic [NPHASE-1:0] phase_q;
    logic [NPHASE-1:0] phase_d;
    logic              halted_q;
    logic              halted_d;
    logic [15:0]       ir;
    logic [3:0]        flags_q;

    // Decode helpers shared by the sequencer and the output decoder
    logic [3:0]  op3;
    logic        is_arith;
    logic        is_hlt;
    logic        flag_op;
    logic [15:0] sext8;
    logic        run;

    assign op3      = ir[7:4];
    assign is_arith = (ir[15:14] == 2'b11);
    assign is_hlt   = is_arith && (op3 == 4'hF);
    assign flag_op  = is_arith && (op3 <= 4'hB);
    assign sext8    = {{8{ir[7]}}, ir[7:0]};
    assign run      = !reset && !halted_q;

    // State register: phase one-hot plus the sticky halt bit
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= RESET_PHASE;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic: advance one phase per clock, HLT freezes at zero
    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (halted_q) begin
            phase_d = '0;
        end else if (phase_q == '0) begin
`ifdef SINGLE_STEP_EN
            if (step) begin
                phase_d = P1_ONEHOT;
            end
`else
            phase_d = P1_ONEHOT;
`endif
        end else if (phase_q[2] && is_hlt) begin
            phase_d  = '0;
            halted_d = 1'b1;
        end else if (phase_q[NPHASE-1]) begin
`ifdef SINGLE_STEP_EN
            phase_d = '0;
`else
            phase_d = P1_ONEHOT;
`endif
        end else begin
            phase_d = phase_q << 1;
        end
    end

    // Instruction register captures the fetched word at the end of P1
    always_ff @(posedge clock) begin
        if (reset) begin
            ir <= 16'h0000;
        end else if (phase_q[0]) begin
            ir <= instr;
        end
    end

    // Condition flags latch at the end of P3 for flag-producing ALU ops only
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (phase_q[2] && flag_op) begin
            flags_q <= cond;
        end
    end

    // Output decode: ALU control fields from ir, strobes qualified by phase
    always_comb begin
        logic wr_rf;
        logic wr_mem;
        logic wr_out;
        logic br_take;
        ALUSrc   = 3'b000;
        ALUOp    = 4'b0000;
        ext_d    = 16'h0000;
        ra_addr  = 3'b000;
        rb_addr  = 3'b000;
        rf_waddr = 3'b000;
        wb_sel   = 2'b00;
        wr_rf    = 1'b0;
        wr_mem   = 1'b0;
        wr_out   = 1'b0;
        br_take  = 1'b0;
        case (ir[15:14])
            2'b11: begin
                ra_addr  = ir[13:11];
                rb_addr  = ir[10:8];
                ALUOp    = op3;
                rf_waddr = ir[10:8];
                case (op3)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4: wr_rf = 1'b1;
                    4'h5: wr_rf = 1'b0;
                    4'h6: begin
                        ALUSrc = 3'b011;
                        wr_rf  = 1'b1;
                    end
                    4'h8, 4'h9, 4'hA, 4'hB: begin
                        ALUSrc = 3'b001;
                        ext_d  = {12'b0, ir[3:0]};
                        wr_rf  = 1'b1;
                    end
                    4'hC: begin
                        wb_sel = 2'b10;
                        wr_rf  = 1'b1;
                    end
                    4'hD: wr_out = 1'b1;
                    default: ;
                endcase
            end
            2'b00: begin
                ra_addr  = ir[13:11];
                rb_addr  = ir[10:8];
                ALUSrc   = 3'b001;
                ext_d    = sext8;
                rf_waddr = ir[13:11];
                wb_sel   = 2'b01;
                wr_rf    = 1'b1;
            end
            2'b01: begin
                ra_addr = ir[13:11];
                rb_addr = ir[10:8];
                ALUSrc  = 3'b001;
                ext_d   = sext8;
                wr_mem  = 1'b1;
            end
            default: begin
                case (ir[13:11])
                    3'b000: begin
                        rb_addr  = ir[10:8];
                        ALUSrc   = 3'b010;
                        ext_d    = sext8;
                        rf_waddr = ir[10:8];
                        wr_rf    = 1'b1;
                    end
                    3'b100: begin
                        ALUSrc  = 3'b100;
                        ext_d   = sext8;
                        br_take = 1'b1;
                    end
                    3'b111: begin
                        ALUSrc = 3'b100;
                        ext_d  = sext8;
                        case (ir[10:8])
                            3'b000:  br_take = flags_q[2];
                            3'b001:  br_take = flags_q[3] ^ flags_q[0];
                            3'b010:  br_take = flags_q[2] | (flags_q[3] ^ flags_q[0]);
                            3'b011:  br_take = !flags_q[2];
                            default: br_take = 1'b0;
                        endcase
                    end
                    default: ;
                endcase
            end
        endcase
        rf_we  = run && phase_q[4] && wr_rf;
        mem_we = run && phase_q[3] && wr_mem;
        out_we = run && phase_q[4] && wr_out;
        pc_we  = run && phase_q[4] && br_take;
        pc_inc = run && phase_q[4] && !br_take;
    end

    assign phasecounter = phase_q;
    assign flags        = flags_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_phase_controller.sv
// tb/tb_phase_controller.sv - scoreboard bench for phase_controller
module tb_phase_controller;

    logic        clock = 1'b0;
    logic        reset;
`ifdef SINGLE_STEP_EN
    logic        step = 1'b1;
`endif
    logic [15:0] instr;
    logic [3:0]  cond;
    logic [4:0]  phasecounter;
    logic [2:0]  ALUSrc;
    logic [3:0]  ALUOp;
    logic [15:0] ext_d;
    logic [2:0]  ra_addr;
    logic [2:0]  rb_addr;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [1:0]  wb_sel;
    logic        mem_we;
    logic        pc_inc;
    logic        pc_we;
    logic        out_we;
    logic [3:0]  flags;
    logic        halted;

    always #5 clock = ~clock;

    phase_controller dut (
        .clock(clock), .reset(reset),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .instr(instr), .cond(cond), .phasecounter(phasecounter),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ext_d(ext_d),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .wb_sel(wb_sel), .mem_we(mem_we),
        .pc_inc(pc_inc), .pc_we(pc_we), .out_we(out_we),
        .flags(flags), .halted(halted)
    );

    typedef struct {
        logic [4:0]  pc;
        logic        dec;
        logic [2:0]  src;
        logic [3:0]  op;
        logic [15:0] ext;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic        rfwe;
        logic [2:0]  waddr;
        logic [1:0]  wb;
        logic        memwe;
        logic        pcinc;
        logic        pcwe;
        logic        outwe;
        logic [3:0]  flg;
        logic        hlt;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad = 0;
    logic [3:0] mflags = 4'b0000;

    // ra/rb/wb passed as X mean "not checked for this instruction"
    task automatic run_instr(input string nm, input logic [15:0] ins, input logic [3:0] c,
                             input logic [2:0] src, input logic [3:0] op, input logic [15:0] ext,
                             input logic [2:0] ra, input logic [2:0] rb,
                             input logic rfwe, input logic [2:0] wa, input logic [1:0] wb,
                             input logic memwe, input logic pcwe, input logic outwe,
                             input logic fupd);
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e.pc = 5'(1 << i); e.dec = (i != 0); e.src = src; e.op = op; e.ext = ext;
            e.ra = ra; e.rb = rb; e.waddr = wa; e.wb = wb;
            e.rfwe = rfwe && (i == 4); e.memwe = memwe && (i == 3);
            e.pcwe = pcwe && (i == 4); e.pcinc = !pcwe && (i == 4); e.outwe = outwe && (i == 4);
            if (i == 3 && fupd) mflags = c;
            e.flg = mflags; e.hlt = 1'b0;
            sb.push_back(e);
        end
        for (int i = 0; i < 5; i++) begin
            instr = (i == 0) ? ins : ~ins;
            cond  = (i == 2) ? c : ~c;
            #1;
            e = sb.pop_front();
            total++; if (phasecounter !== e.pc) begin bad++; $display("FAIL %s phase p%0d: got %b want %b", nm, i+1, phasecounter, e.pc); end
            total++; if (rf_we !== e.rfwe) begin bad++; $display("FAIL %s rf_we p%0d: got %b want %b", nm, i+1, rf_we, e.rfwe); end
            total++; if (mem_we !== e.memwe) begin bad++; $display("FAIL %s mem_we p%0d: got %b want %b", nm, i+1, mem_we, e.memwe); end
            total++; if (pc_inc !== e.pcinc) begin bad++; $display("FAIL %s pc_inc p%0d: got %b want %b", nm, i+1, pc_inc, e.pcinc); end
            total++; if (pc_we !== e.pcwe) begin bad++; $display("FAIL %s pc_we p%0d: got %b want %b", nm, i+1, pc_we, e.pcwe); end
            total++; if (out_we !== e.outwe) begin bad++; $display("FAIL %s out_we p%0d: got %b want %b", nm, i+1, out_we, e.outwe); end
            total++; if (flags !== e.flg) begin bad++; $display("FAIL %s flags p%0d: got %b want %b", nm, i+1, flags, e.flg); end
            total++; if (halted !== e.hlt) begin bad++; $display("FAIL %s halted p%0d: got %b want %b", nm, i+1, halted, e.hlt); end
            if (e.dec) begin
                total++; if (ALUSrc !== e.src) begin bad++; $display("FAIL %s ALUSrc p%0d: got %b want %b", nm, i+1, ALUSrc, e.src); end
                total++; if (ALUOp !== e.op) begin bad++; $display("FAIL %s ALUOp p%0d: got %h want %h", nm, i+1, ALUOp, e.op); end
                total++; if (ext_d !== e.ext) begin bad++; $display("FAIL %s ext_d p%0d: got %h want %h", nm, i+1, ext_d, e.ext); end
                if (!$isunknown(e.ra)) begin
                    total++; if (ra_addr !== e.ra) begin bad++; $display("FAIL %s ra_addr p%0d: got %0d want %0d", nm, i+1, ra_addr, e.ra); end
                end
                if (!$isunknown(e.rb)) begin
                    total++; if (rb_addr !== e.rb) begin bad++; $display("FAIL %s rb_addr p%0d: got %0d want %0d", nm, i+1, rb_addr, e.rb); end
                end
            end
            if (e.rfwe) begin
                total++; if (rf_waddr !== e.waddr) begin bad++; $display("FAIL %s rf_waddr: got %0d want %0d", nm, rf_waddr, e.waddr); end
                if (!$isunknown(e.wb)) begin
                    total++; if (wb_sel !== e.wb) begin bad++; $display("FAIL %s wb_sel: got %b want %b", nm, wb_sel, e.wb); end
                end
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; instr = 16'h0000; cond = 4'b0000;
        repeat (2) @(negedge clock);
        #1;
        total++; if (phasecounter !== 5'b00001) begin bad++; $display("FAIL reset phase: got %b want 00001", phasecounter); end
        total++; if ({rf_we, mem_we, pc_inc, pc_we, out_we} !== 5'b0) begin bad++; $display("FAIL reset strobes: got %b want 00000", {rf_we, mem_we, pc_inc, pc_we, out_we}); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL reset flags: got %b want 0000", flags); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset halted: got %b want 0", halted); end
        reset = 1'b0;
        mflags = 4'b0000;
    endtask

    task automatic test_alu();
        run_instr("add",  16'hC800, 4'b0100, 3'b000, 4'h0, 16'h0000, 3'd1, 3'd0, 1, 3'd0, 2'b00, 0, 0, 0, 1);
        run_instr("li",   16'h83FE, 4'b1111, 3'b010, 4'h0, 16'hFFFE, 3'bx, 3'd3, 1, 3'd3, 2'bxx, 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        run_instr("be_t", 16'hB805, 4'b1111, 3'b100, 4'h0, 16'h0005, 3'bx, 3'bx, 0, 3'd0, 2'bxx, 0, 1, 0, 0);
        run_instr("cmp",  16'hC850, 4'b0000, 3'b000, 4'h5, 16'h0000, 3'd1, 3'd0, 0, 3'd0, 2'bxx, 0, 0, 0, 1);
        run_instr("be_n", 16'hB805, 4'b0100, 3'b100, 4'h0, 16'h0005, 3'bx, 3'bx, 0, 3'd0, 2'bxx, 0, 0, 0, 0);
        run_instr("sll",  16'hC884, 4'b1001, 3'b001, 4'h8, 16'h0004, 3'd1, 3'd0, 1, 3'd0, 2'b00, 0, 0, 0, 1);
        run_instr("blt_n",16'hB9FB, 4'b0000, 3'b100, 4'h0, 16'hFFFB, 3'bx, 3'bx, 0, 3'd0, 2'bxx, 0, 0, 0, 0);
        run_instr("bne_t",16'hBB05, 4'b0100, 3'b100, 4'h0, 16'h0005, 3'bx, 3'bx, 0, 3'd0, 2'bxx, 0, 1, 0, 0);
    endtask

    task automatic test_mem_io();
        run_instr("ld",   16'h0A05, 4'b0110, 3'b001, 4'h0, 16'h0005, 3'd1, 3'd2, 1, 3'd1, 2'b01, 0, 0, 0, 0);
        run_instr("st",   16'h4A03, 4'b0110, 3'b001, 4'h0, 16'h0003, 3'd1, 3'd2, 0, 3'd0, 2'bxx, 1, 0, 0, 0);
        run_instr("in",   16'hC0C0, 4'b0110, 3'b000, 4'hC, 16'h0000, 3'd0, 3'd0, 1, 3'd0, 2'b10, 0, 0, 0, 0);
        run_instr("out",  16'hC0D0, 4'b0110, 3'b000, 4'hD, 16'h0000, 3'd0, 3'd0, 0, 3'd0, 2'bxx, 0, 0, 1, 0);
    endtask

    task automatic test_halt();
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            e.pc = (i < 3) ? 5'(1 << i) : 5'b00000;
            e.hlt = (i >= 3); e.flg = mflags;
            e.rfwe = 0; e.memwe = 0; e.pcinc = 0; e.pcwe = 0; e.outwe = 0;
            sb.push_back(e);
        end
        for (int i = 0; i < 7; i++) begin
            instr = (i == 0) ? 16'hC0F0 : 16'h3F0F;
            cond  = (i == 2) ? 4'b1010 : 4'b0101;
            #1;
            e = sb.pop_front();
            total++; if (phasecounter !== e.pc) begin bad++; $display("FAIL hlt phase c%0d: got %b want %b", i, phasecounter, e.pc); end
            total++; if (halted !== e.hlt) begin bad++; $display("FAIL hlt halted c%0d: got %b want %b", i, halted, e.hlt); end
            total++; if (flags !== e.flg) begin bad++; $display("FAIL hlt flags c%0d: got %b want %b", i, flags, e.flg); end
            total++; if ({rf_we, mem_we, pc_inc, pc_we, out_we} !== 5'b0) begin bad++; $display("FAIL hlt strobes c%0d: got %b want 00000", i, {rf_we, mem_we, pc_inc, pc_we, out_we}); end
            @(negedge clock);
        end
        reset = 1'b1;
        @(negedge clock);
        #1;
        total++; if (phasecounter !== 5'b00001) begin bad++; $display("FAIL hlt_rst phase: got %b want 00001", phasecounter); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL hlt_rst halted: got %b want 0", halted); end
        total++; if (flags !== 4'b0000) begin bad++; $display("FAIL hlt_rst flags: got %b want 0000", flags); end
        reset = 1'b0;
        mflags = 4'b0000;
        @(negedge clock);
        #1;
        total++; if (phasecounter !== 5'b00010) begin bad++; $display("FAIL hlt_rst next phase: got %b want 00010", phasecounter); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mem_io();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
